// File: rtl/fill_arbiter.sv
// fill_arbiter: round-robin sharing of the single block-fill engine among core caches.
// One miss is serviced at a time; block, timeout flag and per-core wait count are returned.
module fill_arbiter #(
   parameter int NUM_CORES  = 4,
   parameter int ADDR_W     = 16,
   parameter int BLOCK_BITS = 128,
   parameter int TIMEOUT    = 64
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_CORES-1:0]        req,
   input  logic [NUM_CORES*ADDR_W-1:0] req_addr,
   output logic                        fill_start,
   output logic [ADDR_W-1:0]           fill_addr,
   input  logic                        fill_ready,
   input  logic [BLOCK_BITS-1:0]       fill_block,
   output logic [NUM_CORES-1:0]        grant,
   output logic [NUM_CORES-1:0]        done,
   output logic [BLOCK_BITS-1:0]       rsp_block,
   output logic                        rsp_err,
   output logic [7:0]                  wait_cycles
);
   localparam int PW = $clog2(NUM_CORES);
   localparam int TW = $clog2(TIMEOUT);
   localparam logic [PW-1:0] LAST_CORE = PW'(NUM_CORES - 1);
   localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

   state_e                 state_q;
   logic [PW-1:0]          rr_ptr_q;
   logic [PW-1:0]          gidx_q;
   logic [TW-1:0]          tmo_q;
   logic                   start_q;
   logic [ADDR_W-1:0]      addr_q;
   logic [NUM_CORES-1:0]   grant_q;
   logic [NUM_CORES-1:0]   done_q;
   logic [BLOCK_BITS-1:0]  blk_q;
   logic                   err_q;
   logic [7:0]             wcnt_q;
   logic [7:0]             cnt_q [NUM_CORES];
   logic [7:0]             cnt_d [NUM_CORES];

   logic                   win_vld;
   logic [PW-1:0]          win_idx;
   logic [NUM_CORES-1:0]   win_oh;
   logic [PW-1:0]          ptr_nxt;

   assign fill_start  = start_q;
   assign fill_addr   = addr_q;
   assign grant       = grant_q;
   assign done        = done_q;
   assign rsp_block   = blk_q;
   assign rsp_err     = err_q;
   assign wait_cycles = wcnt_q;

   assign ptr_nxt = (gidx_q == LAST_CORE) ? '0 : gidx_q + 1'b1;

   // Scan downward so the lowest offset from rr_ptr is the last to win.
   always_comb begin : scan
      logic [PW:0] j;
      j       = '0;
      win_vld = 1'b0;
      win_idx = '0;
      for (int i = NUM_CORES - 1; i >= 0; i--) begin
         j = {1'b0, rr_ptr_q} + (PW+1)'(i);
         if (j >= (PW+1)'(NUM_CORES))
            j = j - (PW+1)'(NUM_CORES);
         if (req[j[PW-1:0]]) begin
            win_vld = 1'b1;
            win_idx = j[PW-1:0];
         end
      end
      win_oh = {{(NUM_CORES-1){1'b0}}, 1'b1} << win_idx;
   end

   always_comb begin
      for (int k = 0; k < NUM_CORES; k++) begin
         cnt_d[k] = cnt_q[k];
         if (!req[k])
            cnt_d[k] = '0;
         else if (cnt_q[k] != 8'hFF)
            cnt_d[k] = cnt_q[k] + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      for (int k = 0; k < NUM_CORES; k++) begin
         if (rst)
            cnt_q[k] <= '0;
         else
            cnt_q[k] <= cnt_d[k];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         rr_ptr_q <= '0;
         gidx_q   <= '0;
         tmo_q    <= '0;
         start_q  <= 1'b0;
         addr_q   <= '0;
         grant_q  <= '0;
         done_q   <= '0;
         blk_q    <= '0;
         err_q    <= 1'b0;
         wcnt_q   <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (win_vld) begin
                  gidx_q  <= win_idx;
                  grant_q <= win_oh;
                  addr_q  <= req_addr[win_idx*ADDR_W +: ADDR_W];
                  start_q <= 1'b1;
                  state_q <= ISSUE;
               end
            end
            ISSUE: begin
               start_q <= 1'b0;
               tmo_q   <= '0;
               state_q <= WAIT;
            end
            WAIT: begin
               if (fill_ready) begin
                  blk_q   <= fill_block;
                  err_q   <= 1'b0;
                  wcnt_q  <= cnt_d[gidx_q];
                  done_q  <= grant_q;
                  state_q <= DONE;
               end else if (tmo_q == TMO_LAST) begin
                  blk_q   <= '0;
                  err_q   <= 1'b1;
                  wcnt_q  <= cnt_d[gidx_q];
                  done_q  <= grant_q;
                  state_q <= DONE;
               end else begin
                  tmo_q <= tmo_q + 1'b1;
               end
            end
            DONE: begin
               done_q   <= '0;
               grant_q  <= '0;
               rr_ptr_q <= ptr_nxt;
               state_q  <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fill_arbiter.sv
// Scoreboard bench for fill_arbiter with a service-schedule reference model.
// Expected results are pushed at grant time; a negedge monitor pops on done.
`timescale 1ns/1ps
module tb_fill_arbiter;
   localparam int N  = 4;
   localparam int AW = 16;
   localparam int BB = 128;
   localparam int TO = 120;
   localparam logic [N-1:0] ONE = 1;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req;
   logic [N*AW-1:0] req_addr;
   logic            fill_start;
   logic [AW-1:0]   fill_addr;
   logic            fill_ready;
   logic [BB-1:0]   fill_block;
   logic [N-1:0]    grant;
   logic [N-1:0]    done;
   logic [BB-1:0]   rsp_block;
   logic            rsp_err;
   logic [7:0]      wait_cycles;

   fill_arbiter #(
      .NUM_CORES(N), .ADDR_W(AW), .BLOCK_BITS(BB), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .rst(rst), .req(req), .req_addr(req_addr),
      .fill_start(fill_start), .fill_addr(fill_addr),
      .fill_ready(fill_ready), .fill_block(fill_block),
      .grant(grant), .done(done), .rsp_block(rsp_block),
      .rsp_err(rsp_err), .wait_cycles(wait_cycles)
   );

   always #5 clk = ~clk;

   typedef struct {
      int            core;
      logic [BB-1:0] blk;
      logic          err;
      logic [7:0]    wcnt;
   } exp_t;

   exp_t exp_q[$];

   int total = 0;
   int bad   = 0;
   int edge_n = 0;

   // reference model of the current service
   bit            m_busy = 0;
   int            m_owner, m_g, m_ek, m_ready;
   logic [AW-1:0] m_addr;
   int            m_ptr = 0;
   logic [BB-1:0] cur_blk;

   int       rise [N];
   logic [N-1:0] prev_req = '0;
   bit       drop_p [N];
   bit       sticky [N];
   bit       reraise [N];
   bit       rand_mode = 0;
   int       d_force = -1;
   bit       blk_force = 0;
   logic [BB-1:0] blk_val;

   function automatic logic [BB-1:0] rnd_blk();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic int pick_d();
      int r;
      r = $urandom_range(0, 19);
      if (r == 0) return 0;
      if (r == 1) return $urandom_range(13, TO);
      return $urandom_range(1, 12);
   endfunction

   task automatic chk(string name, logic [BB-1:0] act, logic [BB-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic raise(int k);
      req[k] = 1'b1;
      req_addr[k*AW +: AW] = AW'($urandom);
   endtask

   task automatic model_edge();
      logic [N-1:0] r;
      exp_t x;
      int w, d, wc;
      r = req;
      if (rst) begin
         if (m_busy && edge_n <= m_ek) x = exp_q.pop_back();
         if (m_busy && edge_n == m_ek + 1) drop_p[m_owner] = 1;
         m_busy   = 0;
         m_ptr    = 0;
         prev_req = '0;
         return;
      end
      for (int k = 0; k < N; k++)
         if (r[k] && !prev_req[k]) rise[k] = edge_n;
      prev_req = r;
      if (!m_busy && r != '0) begin
         w = -1;
         for (int i = 0; i < N; i++)
            if (w < 0 && r[(m_ptr + i) % N]) w = (m_ptr + i) % N;
         d = (d_force >= 0) ? d_force : pick_d();
         m_busy  = 1;
         m_owner = w;
         m_g     = edge_n;
         m_addr  = req_addr[w*AW +: AW];
         cur_blk = blk_force ? blk_val : rnd_blk();
         if (d >= 1 && d <= TO) begin
            m_ek    = edge_n + 1 + d;
            m_ready = m_ek;
            x.err   = 1'b0;
            x.blk   = cur_blk;
         end else begin
            m_ek    = edge_n + 1 + TO;
            m_ready = -1;
            x.err   = 1'b1;
            x.blk   = '0;
         end
         x.core = w;
         wc     = m_ek - rise[w] + 1;
         x.wcnt = (wc > 255) ? 8'd255 : 8'(wc);
         exp_q.push_back(x);
      end else if (m_busy && edge_n == m_ek + 1) begin
         m_busy = 0;
         m_ptr  = (m_owner + 1) % N;
         drop_p[m_owner] = 1;
      end
   endtask

   task automatic drive_next();
      int nx;
      bit in_wait;
      nx = edge_n + 1;
      for (int k = 0; k < N; k++) begin
         if (drop_p[k]) begin
            req[k]     = 1'b0;
            drop_p[k]  = 0;
            reraise[k] = sticky[k];
         end else if (reraise[k]) begin
            reraise[k] = 0;
            if (sticky[k]) raise(k);
         end else if (rand_mode && !req[k] && $urandom_range(0, 3) == 0) begin
            raise(k);
         end
      end
      in_wait    = m_busy && nx >= m_g + 2 && nx <= m_ek;
      fill_block = rnd_blk();
      fill_ready = 1'b0;
      if (m_busy && nx == m_ready) begin
         fill_ready = 1'b1;
         fill_block = cur_blk;
      end else if (rand_mode && !in_wait && $urandom_range(0, 7) == 0) begin
         fill_ready = 1'b1;
      end
   endtask

   task automatic step();
      @(posedge clk);
      edge_n++;
      model_edge();
      #1;
      drive_next();
   endtask

   task automatic run_until_idle(string name, int budget);
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while ((m_busy || req != '0) && n < budget);
      total++;
      if (m_busy || req != '0) begin
         bad++;
         $display("FAIL %s_drain: busy=%0d req=%0h after %0d cycles, want idle",
                  name, m_busy, req, n);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req = '0;
      for (int k = 0; k < N; k++) begin
         sticky[k]  = 0;
         reraise[k] = 0;
      end
      step();
      rst = 1'b0;
   endtask

   task automatic chk_reset_vals(string tag);
      @(negedge clk);
      chk({tag, "_fill_start"}, fill_start, '0);
      chk({tag, "_fill_addr"}, fill_addr, '0);
      chk({tag, "_grant"}, grant, '0);
      chk({tag, "_done"}, done, '0);
      chk({tag, "_rsp_block"}, rsp_block, '0);
      chk({tag, "_rsp_err"}, rsp_err, '0);
      chk({tag, "_wait_cycles"}, wait_cycles, '0);
   endtask

   // monitor: per-cycle handshake checks plus scoreboard pop on done
   initial begin
      logic [N-1:0] eg, ed;
      exp_t x;
      @(posedge clk);
      forever begin
         @(negedge clk);
         eg = m_busy ? (ONE << m_owner) : '0;
         ed = (m_busy && edge_n == m_ek) ? eg : '0;
         chk("grant", grant, eg);
         chk("fill_start", fill_start, (m_busy && edge_n == m_g));
         chk("done", done, ed);
         if (m_busy) chk("fill_addr", fill_addr, m_addr);
         if (done != '0) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL done_unexpected: got done=%0h want none", done);
            end else begin
               x = exp_q.pop_front();
               chk("done_core", done, ONE << x.core);
               chk("rsp_block", rsp_block, x.blk);
               chk("rsp_err", rsp_err, x.err);
               chk("wait_cycles", wait_cycles, x.wcnt);
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst        = 1'b1;
      req        = '0;
      req_addr   = '0;
      fill_ready = 1'b0;
      fill_block = '0;
      for (int k = 0; k < N; k++) begin
         rise[k] = 0; drop_p[k] = 0; sticky[k] = 0; reraise[k] = 0;
      end
      step(); step(); step();
      rst = 1'b0;
      chk_reset_vals("reset");

      // single requester, fill_ready six edges after grant
      d_force   = 5;
      blk_force = 1;
      blk_val   = {16{8'hA5}};
      req_addr[0 +: AW] = 16'h1234;
      req[0] = 1'b1;
      run_until_idle("single", 100);
      blk_force = 0;

      // all four at once, 3-cycle fills, cores keep re-requesting
      do_reset();
      d_force = 3;
      for (int k = 0; k < N; k++) begin
         sticky[k] = 1;
         raise(k);
      end
      repeat (40) step();
      for (int k = 0; k < N; k++) sticky[k] = 0;
      run_until_idle("all4", 200);

      // fairness: core 1 continuous, core 2 once
      d_force   = 4;
      sticky[1] = 1;
      raise(1);
      step(); step();
      raise(2);
      repeat (30) step();
      sticky[1] = 0;
      run_until_idle("fair", 200);

      // timeout, then a stray fill_ready in IDLE
      d_force = 0;
      raise(3);
      run_until_idle("timeout", 300);
      fill_ready = 1'b1;
      step();
      repeat (3) step();

      // reset in the middle of WAIT, then a late fill_ready
      raise(2);
      repeat (6) step();
      do_reset();
      fill_ready = 1'b1;
      step();
      chk_reset_vals("rst_mid");
      d_force = 2;
      raise(0);
      raise(3);
      run_until_idle("after_rst", 100);

      // saturation: core 3 waits behind three 100-cycle fills
      do_reset();
      d_force = 100;
      for (int k = 0; k < N; k++) raise(k);
      run_until_idle("sat", 700);

      // random traffic
      d_force   = -1;
      rand_mode = 1;
      repeat (1500) step();
      rand_mode = 0;
      run_until_idle("random", 1000);
      repeat (3) step();

      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL missing_done: got %0d outstanding, want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
